// File: rtl/demux_16b_8output.sv
// demux_16b_8output
// One producer port steered by Op into eight 16-bit holding channels (A..H).
// Each channel is a two-state EMPTY/FULL handshake slot.
// A slot may be reloaded in the same cycle its consumer acks, which gives full throughput.
// Count tracks accepted writes modulo 256.

module demux_16b_8output (
    input  logic        CLK,
    input  logic        Reset,
    input  logic [15:0] In,
    input  logic [2:0]  Op,
    input  logic        In_valid,
    output logic        In_ready,
    output logic [15:0] A,
    output logic [15:0] B,
    output logic [15:0] C,
    output logic [15:0] D,
    output logic [15:0] E,
    output logic [15:0] F,
    output logic [15:0] G,
    output logic [15:0] H,
    output logic [7:0]  Out_valid,
    input  logic [7:0]  Out_ack,
    output logic [7:0]  Count
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } chan_state_t;

    logic        accept;
    logic [7:0]  sel_onehot;
    logic [15:0] chan_data [8];
    logic [7:0]  count_reg;
    logic [7:0]  count_next;

    // The selected slot can take data when it is empty, or when it is being drained this same cycle
    always_comb begin
        In_ready = ~Out_valid[Op] | Out_ack[Op];
    end

    // A write happens only on a handshake outside reset.
    // At most one slot is chosen, because Op selects exactly one slot.
    always_comb begin
        accept     = In_valid & In_ready & ~Reset;
        sel_onehot = 8'h00;
        if (accept) begin
            sel_onehot[Op] = 1'b1;
        end
    end

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_chan
            chan_state_t state_reg;
            chan_state_t state_next;
            logic        load;
            logic [15:0] data_reg;

            // Slot state register; reset empties every slot
            always_ff @(posedge CLK) begin
                if (Reset) begin
                    state_reg <= EMPTY;
                end else begin
                    state_reg <= state_next;
                end
            end

            // Slot next-state and load decision.
            // An ack on an empty slot is ignored.
            // An ack that coincides with a new write leaves the slot FULL.
            always_comb begin
                state_next = state_reg;
                load       = 1'b0;
                case (state_reg)
                    EMPTY: begin
                        if (sel_onehot[gi]) begin
                            load       = 1'b1;
                            state_next = FULL;
                        end
                    end
                    FULL: begin
                        if (sel_onehot[gi]) begin
                            load       = 1'b1;
                            state_next = FULL;
                        end else if (Out_ack[gi]) begin
                            state_next = EMPTY;
                        end
                    end
                endcase
            end

            // Slot data holds its value after the consumer acks; it changes only on a new write
            always_ff @(posedge CLK) begin
                if (Reset) begin
                    data_reg <= 16'h0000;
                end else if (load) begin
                    data_reg <= In;
                end
            end

            assign Out_valid[gi] = (state_reg == FULL);
            assign chan_data[gi] = data_reg;
        end
    endgenerate

    assign A = chan_data[0];
    assign B = chan_data[1];
    assign C = chan_data[2];
    assign D = chan_data[3];
    assign E = chan_data[4];
    assign F = chan_data[5];
    assign G = chan_data[6];
    assign H = chan_data[7];

    // Accepted-write counter wraps naturally at 8 bits; acks do not affect it
    always_comb begin
        count_next = count_reg + {7'b0, accept};
    end

    // Counter register
    always_ff @(posedge CLK) begin
        if (Reset) begin
            count_reg <= 8'h00;
        end else begin
            count_reg <= count_next;
        end
    end

    assign Count = count_reg;

endmodule

// File: tb/tb_demux_16b_8output.sv
// Scoreboard bench for demux_16b_8output.
// The driver pushes, for each cycle, the expected In_ready and the expected post-edge state.
// The monitor pops and compares on falling edges.

module tb_demux_16b_8output;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] din;
    logic [2:0]  op;
    logic        iv;
    logic        rdy;
    logic [15:0] a, b, c, d, e, f, g, h;
    logic [7:0]  ov;
    logic [7:0]  ack;
    logic [7:0]  cnt;

    always #5 clk = ~clk;

    demux_16b_8output dut (
        .CLK       (clk),
        .Reset     (rst),
        .In        (din),
        .Op        (op),
        .In_valid  (iv),
        .In_ready  (rdy),
        .A         (a),
        .B         (b),
        .C         (c),
        .D         (d),
        .E         (e),
        .F         (f),
        .G         (g),
        .H         (h),
        .Out_valid (ov),
        .Out_ack   (ack),
        .Count     (cnt)
    );

    typedef struct {
        string       name;
        logic        chk_ready;
        logic        exp_ready;
        logic [127:0] exp_data;
        logic [7:0]  exp_valid;
        logic [7:0]  exp_count;
    } sb_t;

    sb_t         sb_q[$];
    sb_t         pend;
    bit          have_pend = 0;
    int          n_checks = 0;
    int          n_pass = 0;
    logic [15:0] ed [8];

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [127:0] pack_ed();
        logic [127:0] v;
        for (int i = 0; i < 8; i++) v[i*16 +: 16] = ed[i];
        return v;
    endfunction

    // One cycle of stimulus plus its expected response
    task automatic step(input string nm, input logic r, input logic [2:0] o,
                        input logic [15:0] dv, input logic v, input logic [7:0] k,
                        input logic cr, input logic er,
                        input logic [7:0] ev, input logic [7:0] ec);
        sb_t t;
        @(posedge clk);
        #1;
        rst = r; op = o; din = dv; iv = v; ack = k;
        t.name      = nm;
        t.chk_ready = cr;
        t.exp_ready = er;
        t.exp_data  = pack_ed();
        t.exp_valid = ev;
        t.exp_count = ec;
        sb_q.push_back(t);
    endtask

    // Monitor: finish the pending transaction's state check, then take the next one's ready check
    initial begin
        forever begin
            @(negedge clk);
            if (have_pend) begin
                chk({pend.name, " data"}, {h, g, f, e, d, c, b, a}, pend.exp_data);
                chk({pend.name, " valid"}, {120'b0, ov}, {120'b0, pend.exp_valid});
                chk({pend.name, " count"}, {120'b0, cnt}, {120'b0, pend.exp_count});
                $display("txn %-10s valid=%h count=%h A..H=%h %h %h %h %h %h %h %h",
                         pend.name, ov, cnt, a, b, c, d, e, f, g, h);
                have_pend = 0;
            end
            if (sb_q.size() > 0) begin
                pend = sb_q.pop_front();
                if (pend.chk_ready) begin
                    chk({pend.name, " ready"}, {127'b0, rdy}, {127'b0, pend.exp_ready});
                end
                have_pend = 1;
            end
        end
    end

    initial begin
        logic [7:0] sweep_valid [8];
        sweep_valid = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF};
        rst = 1'b1; op = 3'd0; din = 16'h0; iv = 1'b0; ack = 8'h00;
        for (int i = 0; i < 8; i++) ed[i] = 16'h0000;

        // Reset, then In_ready must be 1 for every Op
        step("reset", 1, 0, 16'h0, 0, 8'h00, 0, 0, 8'h00, 8'h00);
        for (int k = 0; k < 8; k++)
            step("rdy_rst", 0, 3'(k), 16'h0, 0, 8'h00, 1, 1, 8'h00, 8'h00);

        // Single write to D
        ed[3] = 16'hBEEF;
        step("wr_d", 0, 3, 16'hBEEF, 1, 8'h00, 1, 1, 8'h08, 8'h01);
        // Blocked write: D full, no ack
        step("blocked", 0, 3, 16'h1234, 1, 8'h00, 1, 0, 8'h08, 8'h01);
        // Write with same-cycle ack
        ed[3] = 16'h1234;
        step("pass", 0, 3, 16'h1234, 1, 8'h08, 1, 1, 8'h08, 8'h02);
        // Drain D; data retained
        step("ack_d", 0, 0, 16'h0, 0, 8'h08, 0, 0, 8'h00, 8'h02);

        // Sweep all channels from a fresh reset
        for (int i = 0; i < 8; i++) ed[i] = 16'h0000;
        step("reset2", 1, 0, 16'h0, 0, 8'h00, 0, 0, 8'h00, 8'h00);
        for (int k = 0; k < 8; k++) begin
            ed[k] = 16'(16 * k + 1);
            step("sweep", 0, 3'(k), 16'(16 * k + 1), 1, 8'h00, 1, 1, sweep_valid[k], 8'(k + 1));
        end
        step("ack_all", 0, 0, 16'h0, 0, 8'hFF, 0, 0, 8'h00, 8'h08);
        step("ack_empty", 0, 0, 16'h0, 0, 8'hFF, 0, 0, 8'h00, 8'h08);
        ed[5] = 16'h5555;
        step("wr_f", 0, 5, 16'h5555, 1, 8'h20, 1, 1, 8'h20, 8'h09);
        ed[2] = 16'h2222;
        step("wr_c_ackf", 0, 2, 16'h2222, 1, 8'h20, 1, 1, 8'h04, 8'h0A);

        // Count wrap: 256 accepts alternating channels 0/1 with acks on the written channel
        for (int i = 0; i < 8; i++) ed[i] = 16'h0000;
        step("reset3", 1, 0, 16'h0, 0, 8'h00, 0, 0, 8'h00, 8'h00);
        for (int i = 0; i < 256; i++) begin
            ed[i % 2] = 16'(i);
            step("wrap", 0, 3'(i % 2), 16'(i), 1, 8'(1 << (i % 2)), 1, 1,
                 (i == 0) ? 8'h01 : 8'h03, 8'(i + 1));
        end

        // Reset mid-operation with Out_valid = 8'h5A
        for (int i = 0; i < 8; i++) ed[i] = 16'h0000;
        step("reset4", 1, 0, 16'h0, 0, 8'h00, 0, 0, 8'h00, 8'h00);
        ed[1] = 16'hA001;
        step("mid_w1", 0, 1, 16'hA001, 1, 8'h00, 1, 1, 8'h02, 8'h01);
        ed[3] = 16'hA003;
        step("mid_w3", 0, 3, 16'hA003, 1, 8'h00, 1, 1, 8'h0A, 8'h02);
        ed[4] = 16'hA004;
        step("mid_w4", 0, 4, 16'hA004, 1, 8'h00, 1, 1, 8'h1A, 8'h03);
        ed[6] = 16'hA006;
        step("mid_w6", 0, 6, 16'hA006, 1, 8'h00, 1, 1, 8'h5A, 8'h04);
        for (int i = 0; i < 8; i++) ed[i] = 16'h0000;
        step("mid_rst", 1, 0, 16'hFFFF, 1, 8'h02, 1, 1, 8'h00, 8'h00);
        for (int k = 0; k < 8; k++)
            step("rdy_post", 0, 3'(k), 16'h0, 0, 8'h00, 1, 1, 8'h00, 8'h00);

        @(posedge clk);
        #1;
        iv = 1'b0; ack = 8'h00; rst = 1'b0;
        for (int i = 0; i < 10 && (sb_q.size() > 0 || have_pend); i++) @(posedge clk);
        if (sb_q.size() > 0 || have_pend) begin
            n_checks++;
            $display("FAIL drain: %0d transactions left unchecked, expected 0", sb_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/demux_16b_8output.md
DEMUX_16B_8OUTPUT -- requirements
Module: demux_16b_8output

Interface
REQ-001 The block SHALL have port CLK, input, 1 bit: single clock; all state updates on the rising edge.
REQ-002 The block SHALL have port Reset, input, 1 bit: synchronous, active-high reset, sampled on the rising CLK edge.
REQ-003 The block SHALL have port In, input, 16 bits: write data from the producer.
REQ-004 The block SHALL have port Op, input, 3 bits: destination channel select, 0..7 mapping to A..H.
REQ-005 The block SHALL have port In_valid, input, 1 bit: producer offers In to channel Op this cycle.
REQ-006 The block SHALL have port In_ready, output, 1 bit, combinational: channel Op can accept this cycle.
REQ-007 The block SHALL have ports A, B, C, D, E, F, G and H, each an output of 16 bits: registered holding value of channels 0..7.
REQ-008 The block SHALL have port Out_valid, output, 8 bits: bit i set means channel i holds unconsumed data.
REQ-009 The block SHALL have port Out_ack, input, 8 bits: bit i means the consumer of channel i takes its data this cycle.
REQ-010 The block SHALL have port Count, output, 8 bits: number of accepted writes, modulo 256.

Function
REQ-011 The block SHALL compute In_ready = ~Out_valid[Op] | Out_ack[Op].
- In_ready is a function of current state, Op and Out_ack only.
- In_ready is independent of In_valid.
REQ-012 The block SHALL define an accept as In_valid & In_ready in a cycle with Reset low.
REQ-013 On an accept, the block SHALL, at the next edge:
- load In into channel Op's register;
- set Out_valid[Op];
- leave all other channels unchanged.
- Latency: exactly 1 cycle.
REQ-014 When Out_ack[i] & Out_valid[i] and there is no accept to channel i, the block SHALL clear Out_valid[i] at the next edge.
- The channel i data register SHALL retain its value.
REQ-015 The block SHALL ignore Out_ack[i] while Out_valid[i] is 0: no state change.
REQ-016 On a simultaneous accept to channel i and Out_ack[i] with Out_valid[i] = 1, the block SHALL, at the next edge:
- load the new data into channel i;
- keep Out_valid[i] = 1.
- This is the full-throughput pass case.
REQ-017 When In_valid = 1 and In_ready = 0, the block SHALL take no action: no write, no Count change.
- The producer must hold In and Op until accepted.
REQ-018 Acks on any number of channels in the same cycle SHALL each be honoured independently, alongside at most one accept.
REQ-019 The block SHALL increment Count by 1 per accept, wrapping from 255 to 0.
- Count SHALL NOT change on acks.
REQ-020 The block SHALL never write more than one channel per cycle.
REQ-021 Each channel SHALL behave as a 2-state FSM:
- EMPTY (valid = 0) -> FULL on accept;
- FULL -> EMPTY on ack without accept;
- FULL -> FULL on accept with ack, or on no ack.

Reset
REQ-022 With Reset high at a rising edge, the block SHALL clear A..H to 16'h0000, Out_valid to 8'h00 and Count to 8'h00.
REQ-023 Reset SHALL take priority over simultaneous accepts and acks; any accept in a reset cycle SHALL be discarded.
REQ-024 Immediately after reset, In_ready SHALL be 1 for every Op value.

Verification
REQ-025 The bench SHALL cover reset then single write:
- Stimulus: Reset 1 cycle; then Op=3, In=16'hBEEF, In_valid=1 for 1 cycle.
- Response: next cycle D=16'hBEEF, Out_valid=8'h08, Count=1; all other outputs 0.
REQ-026 The bench SHALL cover a blocked write:
- Stimulus: channel 3 FULL with no ack; Op=3, In=16'h1234, In_valid=1.
- Response: In_ready=0; D stays 16'hBEEF; Count unchanged.
REQ-027 The bench SHALL cover write with same-cycle ack:
- Stimulus: channel 3 FULL; Out_ack=8'h08, Op=3, In=16'h1234, In_valid=1.
- Response: In_ready=1; next cycle D=16'h1234, Out_valid[3]=1, Count+1.
REQ-028 The bench SHALL cover a sweep of all channels:
- Stimulus: write Op=0..7 with In=16'h0010*Op+1 on consecutive cycles; then Out_ack=8'hFF for 1 cycle.
- Response: A..H hold 16'h0001..16'h0071; Out_valid reaches 8'hFF and then 8'h00; data retained; Count=8.
REQ-029 The bench SHALL cover Count wrap:
- Stimulus: 256 accepts, alternating channels with acks.
- Response: Count returns to 8'h00.
REQ-030 The bench SHALL cover reset mid-operation:
- Stimulus: Out_valid=8'h5A; assert Reset together with In_valid=1, Op=0 and Out_ack=8'h02.
- Response: next cycle all outputs 0, Out_valid=8'h00, Count=0; In_ready=1.
